// File: rtl/chol_pkg.sv
// rtl/chol_pkg.sv - Q16.16 constants, FSM states and the saturating multiply shared by the Cholesky datapath.
package chol_pkg;

    localparam int Q_W    = 32;
    localparam int Q_FRAC = 16;

    localparam logic [Q_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [Q_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DIAG,
        ST_SCALE
    } state_t;

    // Signed a times unsigned b, rounded toward -inf, clamped to the Q16.16 range.
    function automatic logic [Q_W-1:0] sat_mul_q16(input logic signed [Q_W-1:0] a,
                                                   input logic        [Q_W-1:0] b);
        logic signed [2*Q_W:0]        pa;
        logic signed [2*Q_W:0]        pb;
        logic signed [2*Q_W:0]        p;
        logic signed [2*Q_W-Q_FRAC:0] s;
        logic        [Q_W-1:0]        r;
        pa = (2*Q_W+1)'(a);
        pb = (2*Q_W+1)'(b);
        p  = pa * pb;
        s  = (2*Q_W-Q_FRAC+1)'(p >>> Q_FRAC);
        if (s[2*Q_W-Q_FRAC:Q_W-1] != {(Q_W-Q_FRAC+2){s[2*Q_W-Q_FRAC]}}) begin
            r = s[2*Q_W-Q_FRAC] ? SAT_MIN : SAT_MAX;
        end else begin
            r = s[Q_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/chol_q16_mul.sv
// rtl/chol_q16_mul.sv - Registered saturating Q16.16 multiplier.
module chol_q16_mul
    import chol_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [Q_W-1:0] a,
    input  logic [Q_W-1:0] b,
    output logic [Q_W-1:0] p
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0;
        end else if (en) begin
            p <= sat_mul_q16(a, b);
        end
    end

endmodule

// File: rtl/chol_col_scale.sv
// rtl/chol_col_scale.sv - Column scaling: requests 1/sqrt(d), emits sqrt(d) then each sub-diagonal element times 1/sqrt(d).
module chol_col_scale
    import chol_pkg::*;
#(
    parameter int N_MAX   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clken,
    input  logic           start,
    input  logic [Q_W-1:0] diag,
    input  logic [3:0]     len,
    output logic           busy,
    output logic [Q_W-1:0] isq_data,
    output logic           isq_data_valid,
    input  logic [Q_W-1:0] isq_out,
    input  logic           isq_out_valid,
    input  logic [Q_W-1:0] elem,
    input  logic           elem_valid,
    output logic           elem_ready,
    output logic [Q_W-1:0] res,
    output logic           res_valid,
    output logic           res_last,
    output logic           err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state_q;
    state_t          state_d;
    logic [Q_W-1:0]  diag_q;
    logic [3:0]      len_q;
    logic [Q_W-1:0]  inv_q;
    logic [3:0]      cnt_q;
    logic [WD_W-1:0] wd_q;
    logic            res_valid_q;
    logic            res_last_q;
    logic            err_q;

    logic            diag_bad;
    logic            wd_expired;
    logic            isq_hit;
    logic            accept;
    logic            last_elem;
    logic [Q_W-1:0]  mul_a;
    logic [Q_W-1:0]  mul_b;

    assign diag_bad   = (diag == '0) || diag[Q_W-1];
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
    assign isq_hit    = (state_q == ST_WAIT) && isq_out_valid;
    assign accept     = (state_q == ST_SCALE) && elem_valid;
    assign last_elem  = (cnt_q == len_q - 4'd1);

    // The diagonal product is formed from the raw isq_out in the WAIT cycle so it lands with DIAG.
    assign mul_a = (state_q == ST_WAIT) ? diag_q  : elem;
    assign mul_b = (state_q == ST_WAIT) ? isq_out : inv_q;

    chol_q16_mul u_mul (
        .clk (clk),
        .rst (rst),
        .en  (clken),
        .a   (mul_a),
        .b   (mul_b),
        .p   (res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (clken) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        busy           = (state_q != ST_IDLE);
        isq_data_valid = 1'b0;
        elem_ready     = 1'b0;
        case (state_q)
            ST_IDLE:  if (start && !diag_bad) state_d = ST_ISSUE;
            ST_ISSUE: begin
                isq_data_valid = 1'b1;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still wins.
                if (isq_out_valid)   state_d = ST_DIAG;
                else if (wd_expired) state_d = ST_IDLE;
            end
            ST_DIAG:  state_d = (len_q == 4'd0) ? ST_IDLE : ST_SCALE;
            ST_SCALE: begin
                elem_ready = 1'b1;
                if (accept && last_elem) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            diag_q      <= '0;
            len_q       <= '0;
            inv_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (clken) begin
            if (state_q == ST_IDLE && start) begin
                diag_q <= diag;
                len_q  <= (len > 4'(N_MAX)) ? 4'(N_MAX) : len;
            end
            if (state_q == ST_ISSUE)     wd_q <= '0;
            else if (state_q == ST_WAIT) wd_q <= wd_q + 1'b1;
            if (isq_hit) inv_q <= isq_out;
            if (state_q == ST_DIAG) cnt_q <= '0;
            else if (accept)        cnt_q <= cnt_q + 4'd1;
            res_valid_q <= isq_hit || accept;
            res_last_q  <= (isq_hit && len_q == 4'd0) || (accept && last_elem);
            err_q       <= (state_q == ST_IDLE && start && diag_bad) ||
                           (state_q == ST_WAIT && !isq_out_valid && wd_expired);
        end
    end

    assign isq_data  = diag_q;
    assign res_valid = res_valid_q;
    assign res_last  = res_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_chol_col_scale.sv
// tb/tb_chol_col_scale.sv - Scoreboard bench for chol_col_scale with directed columns.
module tb_chol_col_scale;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clken = 1'b1;
    logic        start = 1'b0;
    logic [31:0] diag = '0;
    logic [3:0]  len = '0;
    logic        busy;
    logic [31:0] isq_data;
    logic        isq_data_valid;
    logic [31:0] isq_out = '0;
    logic        isq_out_valid = 1'b0;
    logic [31:0] elem = '0;
    logic        elem_valid = 1'b0;
    logic        elem_ready;
    logic [31:0] res;
    logic        res_valid;
    logic        res_last;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_item;
    bit          ready_seen = 1'b0;
    bit          err_early;

    chol_col_scale #(.N_MAX(8), .TIMEOUT(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .clken          (clken),
        .start          (start),
        .diag           (diag),
        .len            (len),
        .busy           (busy),
        .isq_data       (isq_data),
        .isq_data_valid (isq_data_valid),
        .isq_out        (isq_out),
        .isq_out_valid  (isq_out_valid),
        .elem           (elem),
        .elem_valid     (elem_valid),
        .elem_ready     (elem_ready),
        .res            (res),
        .res_valid      (res_valid),
        .res_last       (res_last),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Results count only on cycles the shared clock enable lets the consumer take them.
    always @(negedge clk) begin
        if (rst && clken && res_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_res: got %h, required no result", {res_last, res});
            end else begin
                exp_item = exp_q.pop_front();
                check("res", {res_last, res}, exp_item);
            end
        end
        if (elem_ready) ready_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic last, input logic [31:0] v);
        exp_q.push_back({last, v});
    endtask

    task automatic send_elem(input logic [31:0] v);
        bit took;
        took       = 1'b0;
        elem       = v;
        elem_valid = 1'b1;
        for (int k = 0; k < 20 && !took; k++) begin
            took = elem_ready && clken;
            tick();
        end
        check("elem_accept", took, 1);
    endtask

    task automatic column(input logic [31:0] d, input logic [31:0] inv, input int lat,
                          input logic [3:0] n, input logic [31:0] e0, input logic [31:0] e1,
                          input bit stall);
        diag  = d;
        len   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("isq_valid_rise", isq_data_valid, 1);
        check("isq_data", isq_data, d);
        check("busy_col", busy, 1);
        tick();
        check("isq_valid_fall", isq_data_valid, 0);
        repeat (lat - 1) tick();
        isq_out       = inv;
        isq_out_valid = 1'b1;
        tick();
        isq_out_valid = 1'b0;
        check("diag_latency", res_valid, 1);
        if (n > 0) send_elem(e0);
        if (stall) begin
            clken = 1'b0;
            repeat (5) tick();
            clken = 1'b1;
        end
        if (n > 1) send_elem(e1);
        elem_valid = 1'b0;
        tick();
        check("idle_after_col", busy, 0);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_isq_valid", isq_data_valid, 0);
        check("rst_elem_ready", elem_ready, 0);
        check("rst_res_valid", {res_valid, res_last, err}, 0);
        check("rst_isq_data", isq_data, 0);
        check("rst_res", res, 0);
        tick();
        rst = 1'b1;
        tick();

        push(1'b0, 32'h0001_6A0A);
        push(1'b0, 32'h0000_B505);
        push(1'b1, 32'hFFFF_4AFB);
        column(32'h0002_0000, 32'h0000_B505, 20, 4'd2, 32'h0001_0000, 32'hFFFF_0000, 1'b0);

        ready_seen = 1'b0;
        push(1'b1, 32'h000C_13F9);
        column(32'h00C1_3F9C, 32'h0000_1000, 5, 4'd0, 32'h0, 32'h0, 1'b0);
        check("len0_no_ready", ready_seen, 0);

        push(1'b0, 32'h0010_0000);
        push(1'b0, 32'h7FFF_FFFF);
        push(1'b1, 32'h8000_0000);
        column(32'h0001_0000, 32'h0010_0000, 3, 4'd2, 32'h7FFF_0000, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 2; i++) begin
            diag  = (i == 0) ? 32'h0000_0000 : 32'hFFFE_0000;
            len   = 4'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("illegal_err", err, 1);
            check("illegal_busy", busy, 0);
            check("illegal_no_isq", isq_data_valid, 0);
            tick();
            check("illegal_err_pulse", err, 0);
            check("illegal_busy_after", busy, 0);
        end

        diag  = 32'h0001_0000;
        len   = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        err_early = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (err) err_early = 1'b1;
        end
        check("timeout_early", err_early, 0);
        tick();
        check("timeout_err", err, 1);
        check("timeout_idle", busy, 0);
        isq_out       = 32'h0001_0000;
        isq_out_valid = 1'b1;
        tick();
        isq_out_valid = 1'b0;
        check("late_isq_ignored", res_valid, 0);
        check("late_isq_idle", busy, 0);
        check("timeout_err_pulse", err, 0);

        push(1'b0, 32'h0001_6A0A);
        push(1'b0, 32'h0000_B505);
        push(1'b1, 32'hFFFF_4AFB);
        column(32'h0002_0000, 32'h0000_B505, 20, 4'd2, 32'h0001_0000, 32'hFFFF_0000, 1'b1);

        diag  = 32'h0002_0000;
        len   = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("wait_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_flags", {isq_data_valid, elem_ready, res_valid, res_last, err}, 0);
        check("arst_isq_data", isq_data, 0);
        check("arst_res", res, 0);
        tick();
        rst = 1'b1;
        tick();
        push(1'b0, 32'h0001_6A0A);
        push(1'b0, 32'h0000_B505);
        push(1'b1, 32'hFFFF_4AFB);
        column(32'h0002_0000, 32'h0000_B505, 20, 4'd2, 32'h0001_0000, 32'hFFFF_0000, 1'b0);

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
